// File: rtl/multi_timer_counter.sv
// rtl/multi_timer_counter.sv - N-channel bus-mapped down-counter timer with shared prescaler and maskable interrupt
module multi_timer_counter #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr
);

  logic [NUM_CH-1:0]     en;
  logic [NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]     ie;
  logic [NUM_CH-1:0]     pend;
  logic [CNT_W-1:0]      load_r  [NUM_CH];
  logic [CNT_W-1:0]      count_r [NUM_CH];
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] ps_cnt;

  logic       wr_en;
  logic       rd_en;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;
  logic       wr_prescale;
  logic       wr_pend_all;
  logic       tick;

  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_load;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] clr;

  // Byte-lane bits and the upper window bits take no part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr[11:9], Addr[1:0]};

  assign wr_en       = !CS_N && !WR_N;
  assign rd_en       = !CS_N && !RD_N;
  assign ch_idx      = Addr[7:4];
  assign reg_idx     = Addr[3:2];
  assign wr_prescale = wr_en && Addr[8] && (Addr[7:2] == 6'd1);
  assign wr_pend_all = wr_en && Addr[8] && (Addr[7:2] == 6'd0);
  // A PRESCALE write restarts the phase, so it suppresses the tick of that cycle.
  assign tick        = (ps_cnt == '0) && !wr_prescale;
  assign Intr        = |(pend & ie);

  // Per-channel write decode and tick qualification; register writes win over ticks.
  always_comb begin
    wr_ctrl = '0;
    wr_load = '0;
    run     = '0;
    expire  = '0;
    clr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i] = wr_en && !Addr[8] && (ch_idx == 4'(i)) && (reg_idx == 2'd0);
      wr_load[i] = wr_en && !Addr[8] && (ch_idx == 4'(i)) && (reg_idx == 2'd1);
      clr[i]     = (wr_en && !Addr[8] && (ch_idx == 4'(i)) && (reg_idx == 2'd3) && DataIn[0])
                 || (wr_pend_all && DataIn[i]);
      run[i]     = tick && en[i] && !wr_load[i] && !(wr_ctrl[i] && !DataIn[0]);
      expire[i]  = run[i] && (count_r[i] == '0);
    end
  end

  // Shared prescaler: reload on underflow or on a PRESCALE write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      ps_cnt   <= '0;
    end else if (wr_prescale) begin
      prescale <= DataIn[PRESCALE_W-1:0];
      ps_cnt   <= DataIn[PRESCALE_W-1:0];
    end else if (tick) begin
      ps_cnt <= prescale;
    end else begin
      ps_cnt <= ps_cnt - 1'b1;
    end
  end

  // Channel state: control bits, reload value, counter and sticky pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= '0;
      mode <= '0;
      ie   <= '0;
      pend <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        load_r[i]  <= '0;
        count_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ctrl[i]) begin
          en[i]   <= DataIn[0];
          mode[i] <= DataIn[1];
          ie[i]   <= DataIn[2];
        end else if (expire[i] && !mode[i]) begin
          en[i] <= 1'b0;
        end

        if (wr_load[i]) begin
          load_r[i]  <= DataIn[CNT_W-1:0];
          count_r[i] <= DataIn[CNT_W-1:0];
        end else if (run[i]) begin
          if (count_r[i] == '0)
            count_r[i] <= mode[i] ? load_r[i] : '0;
          else
            count_r[i] <= count_r[i] - 1'b1;
        end

        // Expiry beats a same-cycle clear so no event is lost.
        if (expire[i])
          pend[i] <= 1'b1;
        else if (clr[i])
          pend[i] <= 1'b0;
      end
    end
  end

  // Combinational read mux; unmapped locations and idle strobes read zero.
  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      if (Addr[8]) begin
        case (Addr[7:2])
          6'd0:    DataOut[NUM_CH-1:0]     = pend;
          6'd1:    DataOut[PRESCALE_W-1:0] = prescale;
          default: DataOut = '0;
        endcase
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) begin
            case (reg_idx)
              2'd0:    DataOut[2:0]       = {ie[i], mode[i], en[i]};
              2'd1:    DataOut[CNT_W-1:0] = load_r[i];
              2'd2:    DataOut[CNT_W-1:0] = count_r[i];
              default: DataOut[0]         = pend[i];
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_timer_counter.sv
// tb/tb_multi_timer_counter.sv - self-checking bench for multi_timer_counter
module tb_multi_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Intr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vecs[$];

  multi_timer_counter #(.NUM_CH(4), .CNT_W(32), .PRESCALE_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .WR_N    (WR_N),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Intr    (Intr)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic compare_next(input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got 0x%08h with no expectation queued", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    push_exp(name, exp);
    Addr = a;
    CS_N = 1'b0;
    RD_N = 1'b0;
    #1;
    compare_next(DataOut);
    CS_N = 1'b1;
    RD_N = 1'b1;
  endtask

  task automatic chk_intr(input logic exp, input string name);
    push_exp(name, {31'b0, exp});
    compare_next({31'b0, Intr});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    Addr   = a;
    DataIn = d;
    CS_N   = 1'b0;
    WR_N   = 1'b0;
    @(posedge clk);
    #1;
    CS_N = 1'b1;
    WR_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic add_vec(input logic w, input logic [11:0] a, input logic [31:0] d, input string n);
    vec_t v;
    v.is_wr = w;
    v.addr  = a;
    v.data  = d;
    v.name  = n;
    vecs.push_back(v);
  endtask

  logic [11:0] reg_addrs [6];
  logic [31:0] seq_count [6];
  logic [31:0] seq_pend  [6];

  initial begin
    reg_addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h100, 12'h104};
    seq_count = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    seq_pend  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};

    add_vec(1'b0, 12'h040, 32'h0,  "ch4_ctrl_before");
    add_vec(1'b1, 12'h040, 32'h7,  "ch4_ctrl_wr");
    add_vec(1'b1, 12'h044, 32'h55, "ch4_load_wr");
    add_vec(1'b0, 12'h040, 32'h0,  "ch4_ctrl");
    add_vec(1'b0, 12'h044, 32'h0,  "ch4_load");
    add_vec(1'b0, 12'h048, 32'h0,  "ch4_count");
    add_vec(1'b0, 12'h04C, 32'h0,  "ch4_stat");
    add_vec(1'b0, 12'h004, 32'h2,  "ch0_load_kept");
    add_vec(1'b0, 12'h006, 32'h2,  "ch0_load_bytelane");
    add_vec(1'b0, 12'h000, 32'h4,  "ch0_ctrl_kept");
    add_vec(1'b0, 12'h108, 32'h0,  "undef_global");
    add_vec(1'b0, 12'h100, 32'h0,  "pend_all_idle");

    reset  = 1'b0;
    CS_N   = 1'b1;
    RD_N   = 1'b1;
    WR_N   = 1'b1;
    Addr   = '0;
    DataIn = '0;
    repeat (2) @(negedge clk);

    // Reset state and idle bus
    chk_intr(1'b0, "rst_intr");
    push_exp("rst_dataout_idle", 32'h0);
    compare_next(DataOut);
    reset = 1'b1;
    @(negedge clk);

    // Test 1: reset mid-count with a pending interrupt
    wr(12'h004, 32'd1);
    wr(12'h000, 32'h7);
    repeat (2) @(negedge clk);
    chk_intr(1'b1, "t1_intr_before_reset");
    rd(12'h00C, 32'h1, "t1_stat_before_reset");
    wr(12'h104, 32'd9);
    #2 reset = 1'b0;
    #1 chk_intr(1'b0, "t1_intr_in_reset");
    @(negedge clk);
    for (int i = 0; i < 6; i++) rd(reg_addrs[i], 32'h0, "t1_reg_in_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk_intr(1'b0, "t1_intr_after_reset");
    rd(12'h008, 32'h0, "t1_count_after_reset");
    rd(12'h000, 32'h0, "t1_ctrl_after_reset");
    @(negedge clk);

    // Test 2: one-shot with PRESCALE=3
    wr(12'h104, 32'd3);
    wr(12'h004, 32'd2);
    wr(12'h000, 32'h5);
    rd(12'h008, 32'd2, "t2_count_start");
    repeat (9) @(negedge clk);
    chk_intr(1'b0, "t2_intr_before_expiry");
    rd(12'h008, 32'd0, "t2_count_before_expiry");
    rd(12'h000, 32'h5, "t2_ctrl_before_expiry");
    @(negedge clk);
    chk_intr(1'b1, "t2_intr_at_expiry");
    rd(12'h000, 32'h4, "t2_ctrl_en_cleared");
    rd(12'h008, 32'd0, "t2_count_at_expiry");
    rd(12'h00C, 32'h1, "t2_stat_at_expiry");
    rd(12'h100, 32'h1, "t2_pend_all");
    repeat (8) @(negedge clk);
    rd(12'h008, 32'd0, "t2_count_stays");
    chk_intr(1'b1, "t2_intr_level");
    wr(12'h00C, 32'h1);
    chk_intr(1'b0, "t2_intr_after_w1c");
    rd(12'h00C, 32'h0, "t2_stat_after_w1c");

    // Test 3: periodic ch1, PRESCALE=0
    wr(12'h104, 32'd0);
    wr(12'h014, 32'd4);
    wr(12'h010, 32'h3);
    for (int i = 0; i < 6; i++) begin
      rd(12'h018, seq_count[i], "t3_count_seq");
      rd(12'h01C, seq_pend[i], "t3_pend_seq");
      if (i < 5) @(negedge clk);
    end

    // Test 5: IE masking and PEND_ALL
    chk_intr(1'b0, "t5_intr_masked");
    rd(12'h100, 32'h2, "t5_pend_all_ch1");
    wr(12'h010, 32'h7);
    chk_intr(1'b1, "t5_intr_unmasked");
    rd(12'h018, 32'd3, "t5_count_keeps_running");

    // Test 3 continued: W1C then re-set on next expiry
    wr(12'h01C, 32'h1);
    rd(12'h01C, 32'h0, "t3_stat_cleared");
    chk_intr(1'b0, "t3_intr_cleared");
    rd(12'h018, 32'd2, "t3_count_after_w1c");
    @(negedge clk);
    rd(12'h018, 32'd1, "t3_count_n10");
    @(negedge clk);
    rd(12'h018, 32'd0, "t3_count_n11");
    rd(12'h01C, 32'h0, "t3_stat_n11");
    @(negedge clk);
    rd(12'h018, 32'd4, "t3_count_reload");
    rd(12'h01C, 32'h1, "t3_stat_reset");
    chk_intr(1'b1, "t3_intr_reset");

    // Test 4: W1C landing on the expiry edge
    repeat (4) @(negedge clk);
    rd(12'h018, 32'd0, "t4_count_pre_expiry");
    wr(12'h01C, 32'h1);
    rd(12'h01C, 32'h1, "t4_stat_set_wins");
    chk_intr(1'b1, "t4_intr_set_wins");
    rd(12'h018, 32'd4, "t4_count_reloaded");

    // PEND_ALL W1C, LOAD write against a tick, EN-clearing CTRL write against a tick
    wr(12'h100, 32'h2);
    rd(12'h100, 32'h0, "pend_all_w1c");
    chk_intr(1'b0, "pend_all_w1c_intr");
    rd(12'h018, 32'd3, "count_after_pend_all");
    wr(12'h014, 32'd7);
    rd(12'h018, 32'd7, "load_wins_over_tick");
    @(negedge clk);
    rd(12'h018, 32'd6, "count_after_load");
    wr(12'h010, 32'h0);
    rd(12'h018, 32'd6, "ctrl_disable_wins");
    @(negedge clk);
    rd(12'h018, 32'd6, "count_held_disabled");
    @(negedge clk);

    // Test 6: table of out-of-range/undefined accesses
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, vecs[i].data, vecs[i].name);
        @(negedge clk);
      end
    end

    // Strobe gating of DataOut
    Addr = 12'h004;
    CS_N = 1'b0;
    RD_N = 1'b1;
    push_exp("rd_n_high", 32'h0);
    #1 compare_next(DataOut);
    CS_N = 1'b1;
    RD_N = 1'b0;
    push_exp("cs_n_high", 32'h0);
    #1 compare_next(DataOut);
    RD_N = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
